// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch stage bundle: control, instruction-memory req/rsp and ID-side output
//
// Purpose: groups every non-clock/reset signal of the fetch stage.
//   master : the fetch stage (drives requests and the ID-side output)
//   slave  : the environment (pipeline control, instruction memory, ID)
// Signals:
//   freeze, branch_taken, branch_addr   pipeline control into fetch
//   imem_req_valid/ready/addr           fetch request handshake
//   imem_rsp_valid/data                 in-order instruction return, one per accepted request
//   out_valid/out_pc/out_instr          prefetch queue head towards ID (out_pc is next-PC)
interface if_fetch_queue_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) ();
    logic               freeze;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_addr;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               out_valid;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        input  freeze, branch_taken, branch_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output imem_req_valid, imem_req_addr,
        output out_valid, out_pc, out_instr
    );

    modport slave (
        output freeze, branch_taken, branch_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - credit-limited sequential instruction fetch with prefetch queue and branch flush
//
// Purpose: issues sequential fetches, keeps several in flight, buffers returned
//   instructions in a small queue feeding ID, and redirects on a taken branch by
//   flushing the queue and discarding every response still in flight.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset (0 = reset)
//   bus   if_fetch_queue_if.master (control, imem req/rsp, ID-side output)
module if_fetch_queue #(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                PC_STEP     = 4,
    parameter int                QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_queue_if.master  bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]       DEPTH_W = (CW+1)'(QUEUE_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;

    logic [ADDR_W-1:0]  pc_mem    [QUEUE_DEPTH];
    logic [INSTR_W-1:0] instr_mem [QUEUE_DEPTH];

    logic [CW:0] credit_used;
    logic        req_valid;
    logic        req_fire;
    logic        rsp_v;
    logic        br;
    logic        out_v;
    logic        push;
    logic        pop;

    // A request is only issued when a queue slot is guaranteed for its response,
    // so returning instructions never need back-pressure.
    assign br          = bus.branch_taken;
    assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
    assign req_valid   = rst & ~br & (credit_used < DEPTH_W);
    assign req_fire    = req_valid & bus.imem_req_ready;
    assign rsp_v       = rst & bus.imem_rsp_valid;
    assign out_v       = rst & ~br & (count_q != '0);
    assign pop         = out_v & ~bus.freeze;
    assign push        = rsp_v & ~br & (drop_cnt_q == '0);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.out_valid      = out_v;
    assign bus.out_pc         = out_v ? pc_mem[rd_ptr_q]    : '0;
    assign bus.out_instr      = out_v ? instr_mem[rd_ptr_q] : '0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (br) begin
            fetch_pc_d    = bus.branch_addr;
            rsp_pc_d      = bus.branch_addr;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            outstanding_d = outstanding_q - CW'(rsp_v);
            // Every response still in flight belongs to the old path, including
            // any already marked for dropping by an earlier branch, so the drop
            // count becomes the remaining in-flight count rather than accumulating.
            drop_cnt_d    = outstanding_q - CW'(rsp_v);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + STEP_W;
            end
            if (rsp_v) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - 1'b1;
                end else begin
                    rsp_pc_d = rsp_pc_q + STEP_W;
                end
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_v);
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage needs no reset: entries are only visible while count_q covers them.
    // The stored PC is the next-PC that ID expects.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            pc_mem[wr_ptr_q]    <= rsp_pc_q + STEP_W;
            instr_mem[wr_ptr_q] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue with a variable-latency memory and reference model
module tb_if_fetch_queue;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    if_fetch_queue #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PC_STEP(4), .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct { logic [31:0] addr; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] data; int due; } mrsp_t;

    req_t  inflight[$];
    ent_t  expq[$];
    mrsp_t mpipe[$];
    int    epoch = 0;
    int    cyc = 0;
    int    lat = 1;
    bit    rand_rdy = 1'b0;
    logic [31:0] m_pc = 32'h0;

    int checks = 0;
    int failures = 0;

    logic        e_rv, e_ov;
    logic [31:0] e_addr, e_pc, e_instr;

    // Expected outputs this cycle, from the queue contents and credit rule.
    task automatic sample();
        @(negedge clk);
        e_rv    = rst && !bus.branch_taken && (inflight.size() + expq.size() < QD);
        e_addr  = m_pc;
        e_ov    = rst && !bus.branch_taken && (expq.size() > 0);
        e_pc    = e_ov ? expq[0].pc    : 32'h0;
        e_instr = e_ov ? expq[0].instr : 32'h0;
    endtask

    // Apply the clock edge to the model and to the behavioural memory.
    task automatic advance();
        logic fire, rspv, was_rst;
        logic [31:0] maddr;
        req_t r;
        fire    = bus.imem_req_valid && bus.imem_req_ready;
        rspv    = bus.imem_rsp_valid;
        was_rst = !rst;
        maddr   = bus.imem_req_addr;
        if (!rst) begin
            inflight.delete();
            expq.delete();
            m_pc = 32'h0;
        end else if (bus.branch_taken) begin
            if (rspv && inflight.size() > 0) void'(inflight.pop_front());
            epoch++;
            expq.delete();
            m_pc = bus.branch_addr;
        end else begin
            if (e_ov && !bus.freeze) void'(expq.pop_front());
            if (rspv && inflight.size() > 0) begin
                r = inflight.pop_front();
                if (r.epoch == epoch) expq.push_back('{r.addr + 32'd4, r.addr});
            end
            if (fire) begin
                inflight.push_back('{m_pc, epoch});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) begin
            mpipe.delete();
        end else begin
            if (rspv && mpipe.size() > 0) void'(mpipe.pop_front());
            if (fire) mpipe.push_back('{maddr, cyc + lat - 1});
        end
        bus.imem_rsp_valid = (mpipe.size() > 0) && (mpipe[0].due <= cyc);
        bus.imem_rsp_data  = bus.imem_rsp_valid ? mpipe[0].data : 32'hDEAD_BEEF;
        bus.imem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %0b want 0", bus.imem_req_valid); end
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
            checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc: got %0h want 0", bus.out_pc); end
            checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr: got %0h want 0", bus.out_instr); end
            advance();
        end
    endtask

    task automatic test_stream();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample();
            checks++; if (bus.imem_req_valid !== e_rv) begin failures++; $display("FAIL stream_req_valid: got %0b want %0b", bus.imem_req_valid, e_rv); end
            if (e_rv) begin checks++; if (bus.imem_req_addr !== e_addr) begin failures++; $display("FAIL stream_req_addr: got %0h want %0h", bus.imem_req_addr, e_addr); end end
            checks++; if (bus.out_valid !== (i >= 2)) begin failures++; $display("FAIL stream_out_valid c%0d: got %0b want %0b", i, bus.out_valid, i >= 2); end
            if (i >= 2) begin
                checks++; if (bus.out_pc !== 32'(4 * (i - 1))) begin failures++; $display("FAIL stream_out_pc c%0d: got %0h want %0h", i, bus.out_pc, 4 * (i - 1)); end
                checks++; if (bus.out_instr !== 32'(4 * (i - 2))) begin failures++; $display("FAIL stream_out_instr c%0d: got %0h want %0h", i, bus.out_instr, 4 * (i - 2)); end
            end
            advance();
        end
    endtask

    task automatic test_freeze();
        bus.freeze = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample();
            checks++; if (bus.imem_req_valid !== e_rv) begin failures++; $display("FAIL freeze_req_valid: got %0b want %0b", bus.imem_req_valid, e_rv); end
            checks++; if (bus.out_valid !== e_ov) begin failures++; $display("FAIL freeze_out_valid: got %0b want %0b", bus.out_valid, e_ov); end
            if (e_ov) begin checks++; if (bus.out_pc !== e_pc) begin failures++; $display("FAIL freeze_out_pc: got %0h want %0h", bus.out_pc, e_pc); end end
            if (i == 5) begin checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL freeze_credit_full: got %0b want 0", bus.imem_req_valid); end end
            advance();
        end
        bus.freeze = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            checks++; if (bus.out_valid !== e_ov) begin failures++; $display("FAIL release_out_valid: got %0b want %0b", bus.out_valid, e_ov); end
            if (e_ov) begin
                checks++; if (bus.out_pc !== e_pc) begin failures++; $display("FAIL release_out_pc: got %0h want %0h", bus.out_pc, e_pc); end
                checks++; if (bus.out_instr !== e_instr) begin failures++; $display("FAIL release_out_instr: got %0h want %0h", bus.out_instr, e_instr); end
            end
            advance();
        end
    endtask

    task automatic test_branch_latency();
        bit got;
        lat = 3;
        for (int i = 0; i < 10; i++) begin
            sample();
            checks++; if (bus.imem_req_valid !== e_rv) begin failures++; $display("FAIL lat3_req_valid: got %0b want %0b", bus.imem_req_valid, e_rv); end
            checks++; if (bus.out_valid !== e_ov) begin failures++; $display("FAIL lat3_out_valid: got %0b want %0b", bus.out_valid, e_ov); end
            if (e_ov) begin checks++; if (bus.out_instr !== e_instr) begin failures++; $display("FAIL lat3_out_instr: got %0h want %0h", bus.out_instr, e_instr); end end
            advance();
        end
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'h100;
        sample();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL br_out_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL br_req_valid: got %0b want 0", bus.imem_req_valid); end
        advance();
        bus.branch_taken = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            sample();
            checks++; if (bus.out_valid !== e_ov) begin failures++; $display("FAIL br_drain_out_valid: got %0b want %0b", bus.out_valid, e_ov); end
            if (e_rv) begin checks++; if (bus.imem_req_addr !== e_addr) begin failures++; $display("FAIL br_req_addr: got %0h want %0h", bus.imem_req_addr, e_addr); end end
            if (bus.out_valid === 1'b1) begin
                got = 1'b1;
                checks++; if (bus.out_pc !== 32'h104) begin failures++; $display("FAIL br_first_pc: got %0h want 104", bus.out_pc); end
                checks++; if (bus.out_instr !== 32'h100) begin failures++; $display("FAIL br_first_instr: got %0h want 100", bus.out_instr); end
            end
            advance();
        end
        checks++; if (!got) begin failures++; $display("FAIL br_timeout: got no out_valid want one within 20 cycles"); end
    endtask

    task automatic test_branch_freeze_rsp();
        logic [31:0] tgt;
        bit seen;
        lat = 1;
        seen = bus.imem_rsp_valid;
        for (int i = 0; i < 10 && !seen; i++) begin
            sample();
            advance();
            seen = bus.imem_rsp_valid;
        end
        checks++; if (!seen) begin failures++; $display("FAIL bfr_rsp_timeout: got no rsp_valid want one"); end
        tgt = $urandom & 32'hFFFF_FFFC;
        bus.freeze       = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_addr  = tgt;
        sample();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bfr_out_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL bfr_req_valid: got %0b want 0", bus.imem_req_valid); end
        advance();
        bus.freeze       = 1'b0;
        bus.branch_taken = 1'b0;
        sample();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bfr_queue_empty: got %0b want 0", bus.out_valid); end
        checks++; if (bus.imem_req_addr !== tgt) begin failures++; $display("FAIL bfr_fetch_pc: got %0h want %0h", bus.imem_req_addr, tgt); end
        checks++; if (bus.imem_req_valid !== e_rv) begin failures++; $display("FAIL bfr_req_after: got %0b want %0b", bus.imem_req_valid, e_rv); end
        advance();
        for (int i = 0; i < 6; i++) begin
            sample();
            checks++; if (bus.out_valid !== e_ov) begin failures++; $display("FAIL bfr_next_out_valid: got %0b want %0b", bus.out_valid, e_ov); end
            if (e_ov) begin checks++; if (bus.out_instr !== e_instr) begin failures++; $display("FAIL bfr_next_instr: got %0h want %0h", bus.out_instr, e_instr); end end
            advance();
        end
    endtask

    task automatic test_wrap();
        bit seen_top, seen_zero;
        seen_top  = 1'b0;
        seen_zero = 1'b0;
        lat = 2;
        rand_rdy = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_addr  = 32'hFFFF_FFF8;
        sample();
        advance();
        bus.branch_taken = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.freeze = ($urandom_range(0, 3) == 0);
            sample();
            checks++; if (bus.imem_req_valid !== e_rv) begin failures++; $display("FAIL wrap_req_valid: got %0b want %0b", bus.imem_req_valid, e_rv); end
            if (e_rv) begin checks++; if (bus.imem_req_addr !== e_addr) begin failures++; $display("FAIL wrap_req_addr: got %0h want %0h", bus.imem_req_addr, e_addr); end end
            checks++; if (bus.out_valid !== e_ov) begin failures++; $display("FAIL wrap_out_valid: got %0b want %0b", bus.out_valid, e_ov); end
            if (e_ov) begin
                checks++; if (bus.out_pc !== e_pc) begin failures++; $display("FAIL wrap_out_pc: got %0h want %0h", bus.out_pc, e_pc); end
                checks++; if (bus.out_instr !== e_instr) begin failures++; $display("FAIL wrap_out_instr: got %0h want %0h", bus.out_instr, e_instr); end
                if (bus.out_instr === 32'hFFFF_FFFC) seen_top = 1'b1;
                if (seen_top && bus.out_instr === 32'h0) seen_zero = 1'b1;
            end
            advance();
        end
        checks++; if (!seen_zero) begin failures++; $display("FAIL wrap_order: got no 0 after FFFFFFFC want wrap in order"); end
        bus.freeze = 1'b0;
        rand_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        lat = 1;
        for (int i = 0; i < 5; i++) begin
            sample();
            advance();
        end
        rst = 1'b0;
        sample();
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL midrst_req_valid: got %0b want 0", bus.imem_req_valid); end
        advance();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (i == 0) begin
                checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %0b want 0", bus.out_valid); end
                checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL midrst_out_pc: got %0h want 0", bus.out_pc); end
                checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("FAIL midrst_out_instr: got %0h want 0", bus.out_instr); end
                checks++; if (bus.imem_req_addr !== 32'h0) begin failures++; $display("FAIL midrst_refetch: got %0h want 0", bus.imem_req_addr); end
            end
            if (i == 2) begin
                checks++; if (bus.out_pc !== 32'h4) begin failures++; $display("FAIL midrst_first_pc: got %0h want 4", bus.out_pc); end
            end
            checks++; if (bus.out_valid !== e_ov) begin failures++; $display("FAIL midrst_model_valid: got %0b want %0b", bus.out_valid, e_ov); end
            if (e_ov) begin checks++; if (bus.out_instr !== e_instr) begin failures++; $display("FAIL midrst_model_instr: got %0h want %0h", bus.out_instr, e_instr); end end
            advance();
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.freeze         = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.branch_addr    = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_freeze();
        test_branch_latency();
        test_branch_freeze_rsp();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
